// File: rtl/multicore_debug_halt_sequencer.sv
// -----------------------------------------------------------------------------
// multicore_debug_halt_sequencer
//
// Coordinates debug halt/resume across the Nios II cores of the multicore Sobel
// system. A break hit on any enabled core, or a host halt pulse, raises
// debugreq on every enabled core and waits for all debugack lines. Then a host
// resume pulse drops debugreq and waits for the acks to clear. Each of these two
// phases has a timeout.
//
// Optional feature (compile-time macro DBG_HALT_COUNT_EN):
//   defined   -> halt_count counts HALT_REQ->HALTED transitions (wraps at 16 bits)
//   undefined -> halt_count is tied to zero and no counter is built
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   core_enable         per-core participation mask (sampled only while idle)
//   core_break_hit      per-core break/trigger hit (level)
//   host_halt_req       host halt pulse
//   host_resume_req     host resume pulse
//   debugack            per-core "in debug mode" acknowledge
//   debugreq            per-core debug request
//   all_halted          every masked core acknowledged the halt
//   halt_timeout        last halt/resume phase timed out (sticky until next halt)
//   stuck_mask          masked cores that failed to respond at timeout
//   src_valid           src_host/src_idx describe the current halt
//   src_host            current halt was started by the host
//   src_idx             core whose break hit started the current halt
//   busy                sequencer is not idle
//   halt_count          completed halt count
// -----------------------------------------------------------------------------
module multicore_debug_halt_sequencer #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned IDX_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] core_enable,
  input  logic [NUM_CORES-1:0] core_break_hit,
  input  logic                 host_halt_req,
  input  logic                 host_resume_req,
  input  logic [NUM_CORES-1:0] debugack,
  output logic [NUM_CORES-1:0] debugreq,
  output logic                 all_halted,
  output logic                 halt_timeout,
  output logic [NUM_CORES-1:0] stuck_mask,
  output logic                 src_valid,
  output logic                 src_host,
  output logic [IDX_W-1:0]     src_idx,
  output logic                 busy,
  output logic [15:0]          halt_count
);

  // Timer only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned      TMR_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HALT_REQ = 2'd1,
    S_HALTED   = 2'd2,
    S_RESUME   = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [NUM_CORES-1:0] mask, mask_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [TMR_W-1:0]     timer, timer_nxt;

  logic [NUM_CORES-1:0] debugreq_nxt;
  logic                 all_halted_nxt;
  logic                 halt_timeout_nxt;
  logic [NUM_CORES-1:0] stuck_mask_nxt;
  logic                 src_valid_nxt;
  logic                 src_host_nxt;
  logic [IDX_W-1:0]     src_idx_nxt;
  logic                 busy_nxt;

  logic [NUM_CORES-1:0] req_c;
  logic [IDX_W-1:0]     win_c;
  logic                 halt_start_c;
  logic                 acked_c;
  logic                 released_c;
  logic                 timer_done_c;

  // First requesting core at or after ptr, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                               input logic [IDX_W-1:0]     ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      cand;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand = (32'(ptr) + k) % NUM_CORES;
      if (!found && req[IDX_W'(cand)]) begin
        pick  = IDX_W'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Request decode and phase-completion conditions.
  always_comb begin
    req_c        = core_break_hit & core_enable;
    win_c        = rr_pick(req_c, rr_ptr);
    halt_start_c = (core_enable != '0) && ((req_c != '0) || host_halt_req);
    acked_c      = ((debugack & mask) == mask);
    released_c   = ((debugack & mask) == '0);
    timer_done_c = (timer == TMR_LAST);
  end

  // State register plus all registered outputs and bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      mask         <= '0;
      rr_ptr       <= '0;
      timer        <= '0;
      debugreq     <= '0;
      all_halted   <= 1'b0;
      halt_timeout <= 1'b0;
      stuck_mask   <= '0;
      src_valid    <= 1'b0;
      src_host     <= 1'b0;
      src_idx      <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      mask         <= mask_nxt;
      rr_ptr       <= rr_ptr_nxt;
      timer        <= timer_nxt;
      debugreq     <= debugreq_nxt;
      all_halted   <= all_halted_nxt;
      halt_timeout <= halt_timeout_nxt;
      stuck_mask   <= stuck_mask_nxt;
      src_valid    <= src_valid_nxt;
      src_host     <= src_host_nxt;
      src_idx      <= src_idx_nxt;
      busy         <= busy_nxt;
    end
  end

  // Next-state logic. A resume pulse during HALT_REQ aborts the halt outright.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (halt_start_c) state_nxt = S_HALT_REQ;
      end
      S_HALT_REQ: begin
        if (host_resume_req)             state_nxt = S_RESUME;
        else if (acked_c || timer_done_c) state_nxt = S_HALTED;
      end
      S_HALTED: begin
        if (host_resume_req) state_nxt = S_RESUME;
      end
      S_RESUME: begin
        if (released_c || timer_done_c) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and bookkeeping.
  always_comb begin
    mask_nxt         = mask;
    rr_ptr_nxt       = rr_ptr;
    timer_nxt        = timer;
    debugreq_nxt     = debugreq;
    all_halted_nxt   = all_halted;
    halt_timeout_nxt = halt_timeout;
    stuck_mask_nxt   = stuck_mask;
    src_valid_nxt    = src_valid;
    src_host_nxt     = src_host;
    src_idx_nxt      = src_idx;
    busy_nxt         = (state_nxt != S_IDLE);

    case (state)
      S_IDLE: begin
        mask_nxt = core_enable;
        if (halt_start_c) begin
          // A core hit beats a simultaneous host request.
          if (req_c != '0) begin
            src_idx_nxt  = win_c;
            src_host_nxt = 1'b0;
            rr_ptr_nxt   = (win_c == IDX_LAST) ? '0 : win_c + IDX_W'(1);
          end else begin
            src_host_nxt = 1'b1;
          end
          debugreq_nxt     = core_enable;
          src_valid_nxt    = 1'b1;
          halt_timeout_nxt = 1'b0;
          stuck_mask_nxt   = '0;
          timer_nxt        = '0;
        end
      end
      S_HALT_REQ: begin
        timer_nxt = timer + TMR_W'(1);
        if (host_resume_req) begin
          debugreq_nxt = '0;
          timer_nxt    = '0;
        end else if (acked_c) begin
          // Ack beats a timeout landing on the same cycle.
          all_halted_nxt = 1'b1;
        end else if (timer_done_c) begin
          all_halted_nxt   = 1'b0;
          halt_timeout_nxt = 1'b1;
          stuck_mask_nxt   = mask & ~debugack;
        end
      end
      S_HALTED: begin
        if (host_resume_req) begin
          debugreq_nxt   = '0;
          all_halted_nxt = 1'b0;
          timer_nxt      = '0;
        end
      end
      S_RESUME: begin
        timer_nxt = timer + TMR_W'(1);
        if (released_c) begin
          src_valid_nxt = 1'b0;
        end else if (timer_done_c) begin
          src_valid_nxt    = 1'b0;
          halt_timeout_nxt = 1'b1;
          stuck_mask_nxt   = mask & debugack;
        end
      end
      default: ;
    endcase
  end

`ifdef DBG_HALT_COUNT_EN
  // Completed-halt counter, both acked and timed-out halts.
  logic        halt_done_c;
  logic [15:0] halt_cnt_q;

  assign halt_done_c = (state == S_HALT_REQ) && (state_nxt == S_HALTED);

  always_ff @(posedge clk) begin
    if (reset)            halt_cnt_q <= 16'd0;
    else if (halt_done_c) halt_cnt_q <= halt_cnt_q + 16'd1;
  end

  assign halt_count = halt_cnt_q;
`else
  assign halt_count = 16'd0;
`endif

endmodule

// File: tb/tb_multicore_debug_halt_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for multicore_debug_halt_sequencer: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural model of the
// halt/resume protocol.
// -----------------------------------------------------------------------------
module tb_multicore_debug_halt_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;
  localparam int unsigned IW = 2;

  localparam int PH_IDLE = 0, PH_REQ = 1, PH_HALT = 2, PH_RES = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  core_enable;
  logic [N-1:0]  core_break_hit;
  logic          host_halt_req;
  logic          host_resume_req;
  logic [N-1:0]  debugack;
  logic [N-1:0]  debugreq;
  logic          all_halted;
  logic          halt_timeout;
  logic [N-1:0]  stuck_mask;
  logic          src_valid;
  logic          src_host;
  logic [IW-1:0] src_idx;
  logic          busy;
  logic [15:0]   halt_count;

  always #5 clk = ~clk;

  multicore_debug_halt_sequencer #(
    .NUM_CORES(N),
    .TIMEOUT_CYCLES(TO),
    .IDX_W(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_enable(core_enable),
    .core_break_hit(core_break_hit),
    .host_halt_req(host_halt_req),
    .host_resume_req(host_resume_req),
    .debugack(debugack),
    .debugreq(debugreq),
    .all_halted(all_halted),
    .halt_timeout(halt_timeout),
    .stuck_mask(stuck_mask),
    .src_valid(src_valid),
    .src_host(src_host),
    .src_idx(src_idx),
    .busy(busy),
    .halt_count(halt_count)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  int           ph;
  int           age;
  int           m_rr;
  int           m_idx;
  logic [N-1:0] m_mask, m_dreq, m_stuck;
  logic         m_all, m_to, m_valid, m_host;
  logic [15:0]  m_cnt;

  // Requesting core nearest to rr going upward (modulo N), or -1.
  function automatic int pick(input logic [N-1:0] req, input int rr);
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        int d = (i - rr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    ph = PH_IDLE; age = 0; m_rr = 0; m_idx = 0;
    m_mask = '0; m_dreq = '0; m_stuck = '0;
    m_all = 1'b0; m_to = 1'b0; m_valid = 1'b0; m_host = 1'b0;
    m_cnt = 16'd0;
  endtask

  // One clock edge of the protocol, using the inputs as they stand.
  task automatic model_edge();
    logic [N-1:0] req;
    int w;
    if (reset) begin
      model_reset();
      return;
    end
    case (ph)
      PH_IDLE: begin
        m_mask = core_enable;
        req    = core_break_hit & core_enable;
        if (core_enable != '0 && (req != '0 || host_halt_req)) begin
          if (req != '0) begin
            w      = pick(req, m_rr);
            m_idx  = w;
            m_host = 1'b0;
            m_rr   = (w + 1) % N;
          end else begin
            m_host = 1'b1;
          end
          m_dreq = core_enable; m_valid = 1'b1; m_to = 1'b0; m_stuck = '0;
          age = 0; ph = PH_REQ;
        end
      end
      PH_REQ: begin
        if (host_resume_req) begin
          m_dreq = '0; age = 0; ph = PH_RES;
        end else if ((debugack & m_mask) == m_mask) begin
          m_all = 1'b1; m_cnt = m_cnt + 16'd1; ph = PH_HALT;
        end else if (age == TO - 1) begin
          m_all = 1'b0; m_to = 1'b1; m_stuck = m_mask & ~debugack;
          m_cnt = m_cnt + 16'd1; ph = PH_HALT;
        end else begin
          age++;
        end
      end
      PH_HALT: begin
        if (host_resume_req) begin
          m_dreq = '0; m_all = 1'b0; age = 0; ph = PH_RES;
        end
      end
      default: begin
        if ((debugack & m_mask) == '0) begin
          m_valid = 1'b0; ph = PH_IDLE;
        end else if (age == TO - 1) begin
          m_to = 1'b1; m_stuck = m_mask & debugack; m_valid = 1'b0; ph = PH_IDLE;
        end else begin
          age++;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_cnt;
`ifdef DBG_HALT_COUNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 16'd0;
`endif
    chk(tag, "debugreq",     32'(debugreq),     32'(m_dreq));
    chk(tag, "all_halted",   32'(all_halted),   32'(m_all));
    chk(tag, "halt_timeout", 32'(halt_timeout), 32'(m_to));
    chk(tag, "stuck_mask",   32'(stuck_mask),   32'(m_stuck));
    chk(tag, "src_valid",    32'(src_valid),    32'(m_valid));
    chk(tag, "src_host",     32'(src_host),     32'(m_host));
    chk(tag, "src_idx",      32'(src_idx),      32'(m_idx));
    chk(tag, "busy",         32'(busy),         32'(ph != PH_IDLE));
    chk(tag, "halt_count",   32'(halt_count),   32'(exp_cnt));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Resume from HALTED and let the acks drop.
  task automatic finish_halt(input string tag);
    host_resume_req = 1'b1;
    step(tag);
    host_resume_req = 1'b0;
    debugack        = '0;
    step(tag);
  endtask

  initial begin
    int exp_seq[3] = '{1, 3, 1};
    logic [15:0] exp5;

    model_reset();
    reset = 1'b1; core_enable = '0; core_break_hit = '0;
    host_halt_req = 1'b0; host_resume_req = 1'b0; debugack = '0;
    @(negedge clk);
    step("reset");
    chk("reset", "busy_const", 32'(busy), 32'd0);
    chk("reset", "dreq_const", 32'(debugreq), 32'd0);
    reset = 1'b0; core_enable = 4'b1111;
    step("idle");

    // Single break hit on core 2, ack three cycles later, then resume.
    core_break_hit = 4'b0100;
    step("tp1_hit");
    chk("tp1", "dreq_const", 32'(debugreq), 32'(4'b1111));
    chk("tp1", "idx_const", 32'(src_idx), 32'd2);
    chk("tp1", "host_const", 32'(src_host), 32'd0);
    core_break_hit = '0;
    step("tp1_wait");
    step("tp1_wait");
    debugack = 4'b1111;
    step("tp1_ack");
    chk("tp1", "all_halted_const", 32'(all_halted), 32'd1);
    finish_halt("tp1_res");
    chk("tp1", "busy_end_const", 32'(busy), 32'd0);

    // Held hits on cores 1 and 3 rotate the winner.
    reset = 1'b1;
    step("tp2_rst");
    reset = 1'b0; core_break_hit = 4'b1010;
    for (int r = 0; r < 3; r++) begin
      step("tp2_start");
      chk("tp2", "idx_seq", 32'(src_idx), 32'(exp_seq[r]));
      debugack = 4'b1111;
      step("tp2_ack");
      finish_halt("tp2_res");
    end
    core_break_hit = '0;
    step("tp2_idle");

    // Core hit beats host; host alone keeps the previous index.
    host_halt_req = 1'b1; core_break_hit = 4'b0001;
    step("tp3_both");
    host_halt_req = 1'b0; core_break_hit = '0;
    chk("tp3", "host_const", 32'(src_host), 32'd0);
    chk("tp3", "idx_const", 32'(src_idx), 32'd0);
    debugack = 4'b1111;
    step("tp3_ack");
    finish_halt("tp3_res");
    host_halt_req = 1'b1;
    step("tp3_host");
    host_halt_req = 1'b0;
    chk("tp3", "host_only_const", 32'(src_host), 32'd1);
    debugack = 4'b1111;
    step("tp3_ack2");
    finish_halt("tp3_res2");

    // Halt timeout with core 2 never acknowledging.
    host_halt_req = 1'b1;
    step("tp4_start");
    host_halt_req = 1'b0; debugack = 4'b1011;
    for (int i = 1; i < 8; i++) step("tp4_wait");
    chk("tp4", "no_timeout_yet", 32'(halt_timeout), 32'd0);
    step("tp4_to");
    chk("tp4", "timeout_const", 32'(halt_timeout), 32'd1);
    chk("tp4", "stuck_const", 32'(stuck_mask), 32'(4'b0100));
    chk("tp4", "all_halted_const", 32'(all_halted), 32'd0);
    finish_halt("tp4_res");
    chk("tp4", "timeout_sticky", 32'(halt_timeout), 32'd1);

    // Masked-out hit ignored; mask frozen while halted.
    core_enable = 4'b0011; core_break_hit = 4'b1000;
    step("tp5_ignored");
    chk("tp5", "busy_const", 32'(busy), 32'd0);
    core_break_hit = 4'b0001;
    step("tp5_start");
    core_break_hit = '0;
    chk("tp5", "dreq_const", 32'(debugreq), 32'(4'b0011));
    debugack = 4'b0111;
    step("tp5_ack");
    chk("tp5", "all_halted_const", 32'(all_halted), 32'd1);
    core_enable = 4'b1111;
    step("tp5_held");
    chk("tp5", "dreq_held", 32'(debugreq), 32'(4'b0011));
    finish_halt("tp5_res");

    // Empty enable mask ignores the host too.
    core_enable = '0; host_halt_req = 1'b1;
    step("empty_mask");
    host_halt_req = 1'b0; core_enable = 4'b1111;
    chk("empty_mask", "busy_const", 32'(busy), 32'd0);

    // Reset in the middle of HALT_REQ.
    host_halt_req = 1'b1;
    step("tp6_start");
    host_halt_req = 1'b0;
    step("tp6_mid");
    reset = 1'b1;
    step("tp6_rst");
    chk("tp6", "dreq_const", 32'(debugreq), 32'd0);
    chk("tp6", "valid_const", 32'(src_valid), 32'd0);
    chk("tp6", "busy_const", 32'(busy), 32'd0);
    reset = 1'b0;

    // Five completed halts.
    for (int h = 0; h < 5; h++) begin
      host_halt_req = 1'b1;
      step("cnt_start");
      host_halt_req = 1'b0; debugack = 4'b1111;
      step("cnt_ack");
      finish_halt("cnt_res");
    end
`ifdef DBG_HALT_COUNT_EN
    exp5 = 16'd5;
`else
    exp5 = 16'd0;
`endif
    chk("cnt", "five_halts", 32'(halt_count), 32'(exp5));

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 299) == 0);
      core_enable     = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b1111;
      core_break_hit  = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      host_halt_req   = ($urandom_range(0, 7) == 0);
      host_resume_req = ($urandom_range(0, 9) == 0);
      case (ph)
        PH_REQ:  debugack = ($urandom_range(0, 3) != 0) ? (m_mask | N'($urandom)) : N'($urandom);
        PH_RES:  debugack = ($urandom_range(0, 2) != 0) ? '0 : N'($urandom);
        default: debugack = N'($urandom);
      endcase
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
